// File: rtl/zint_gen.sv
// Z80 maskable-interrupt timing generator: counts T-states per frame and
// issues an int_start strobe plus a fixed-width active-low INT pulse.
module zint_gen #(
    parameter int FRAME_LEN = 71680,
    parameter int INT_WIDTH = 32
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        frame_sync,
    input  logic        int_en,
    input  logic [16:0] int_pos,
    input  logic        m1_n,
    input  logic        iorq_n,
    output logic        int_start,
    output logic        int_n,
    output logic        int_ack,
    output logic [16:0] tcnt
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [16:0] FRAME_LAST = 17'(FRAME_LEN - 1);
    localparam logic [5:0]  WIDTH_INIT = 6'(INT_WIDTH);

    state_t      state_q, state_d;
    logic [16:0] tcnt_q, tcnt_d;
    logic [5:0]  width_q, width_d;
    logic        int_n_q, int_n_d;
    logic        int_start_q, int_start_d;
    logic        int_ack_q, int_ack_d;
    logic        match;
    logic        intack;

    always_comb begin
        tcnt_d = tcnt_q;
        if (frame_sync) begin
            tcnt_d = '0;
        end else if (zpos) begin
            tcnt_d = (tcnt_q == FRAME_LAST) ? '0 : tcnt_q + 17'd1;
        end
    end

    // Match uses the pre-update counter, so it still fires alongside frame_sync.
    assign match  = zpos && int_en && (tcnt_q == int_pos) && (int_pos <= FRAME_LAST)
                    && (state_q == IDLE);
    assign intack = zneg && !m1_n && !iorq_n;

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        int_n_d     = int_n_q;
        int_start_d = 1'b0;
        int_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (match) begin
                    state_d     = ACTIVE;
                    int_start_d = 1'b1;
                    int_n_d     = 1'b0;
                    width_d     = WIDTH_INIT;
                end
            end
            ACTIVE: begin
                if (intack) begin
                    state_d   = IDLE;
                    int_n_d   = 1'b1;
                    int_ack_d = 1'b1;
                    width_d   = '0;
                end else if (!int_en) begin
                    state_d = IDLE;
                    int_n_d = 1'b1;
                    width_d = '0;
                end else if (zpos) begin
                    width_d = width_q - 6'd1;
                    if (width_q == 6'd1) begin
                        state_d = IDLE;
                        int_n_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                int_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            width_q     <= '0;
            int_n_q     <= 1'b1;
            int_start_q <= 1'b0;
            int_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            width_q     <= width_d;
            int_n_q     <= int_n_d;
            int_start_q <= int_start_d;
            int_ack_q   <= int_ack_d;
        end
    end

    assign int_start = int_start_q;
    assign int_n     = int_n_q;
    assign int_ack   = int_ack_q;
    assign tcnt      = tcnt_q;

endmodule

// File: tb/tb_zint_gen.sv
// Bench for zint_gen: a frame/interrupt model predicts timestamped events
// into a queue; a negedge monitor matches what the DUT actually emits.
module tb_zint_gen;

    localparam int FL = 100;
    localparam int W  = 4;
    localparam int EV_START = 0;
    localparam int EV_ACK   = 1;
    localparam int EV_END   = 2;

    typedef struct {
        int kind;
        int stamp;
        int tc;
    } ev_t;

    logic        fclk = 1'b0;
    logic        rst;
    logic        zpos, zneg, frame_sync, int_en, m1_n, iorq_n;
    logic [16:0] int_pos;
    logic        int_start, int_n, int_ack;
    logic [16:0] tcnt;

    zint_gen #(.FRAME_LEN(FL), .INT_WIDTH(W)) dut (
        .fclk(fclk), .rst(rst), .zpos(zpos), .zneg(zneg), .frame_sync(frame_sync),
        .int_en(int_en), .int_pos(int_pos), .m1_n(m1_n), .iorq_n(iorq_n),
        .int_start(int_start), .int_n(int_n), .int_ack(int_ack), .tcnt(tcnt)
    );

    always #5 fclk = ~fclk;

    int  checks = 0;
    int  failures = 0;
    int  edge_count = 0;
    int  start_cnt = 0;
    int  tc_chk = 0;
    int  ph = 0;
    bit  mon_on = 0;
    ev_t expq[$];

    int  m_tcnt = 0;
    bit  m_active = 0;
    int  m_rem = 0;

    bit  ack_mode = 0, dis_mode = 0, fs57_mode = 0, fs10_mode = 0, rnd_mode = 0;

    function automatic string ev_name(int k);
        return (k == EV_START) ? "int_start" : (k == EV_ACK) ? "int_ack" : "int_n_rise";
    endfunction

    task automatic check_output(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_count);
        end
    endtask

    task automatic push_ev(int kind, int stamp, int tc);
        ev_t e;
        e.kind = kind;
        e.stamp = stamp;
        e.tc = tc;
        expq.push_back(e);
    endtask

    // Reference: frame position is modular arithmetic, INT is "W zpos remaining".
    task automatic model_step();
        int stamp;
        int nt;
        stamp = edge_count + 1;
        nt = frame_sync ? 0 : (zpos ? (m_tcnt + 1) % FL : m_tcnt);
        if (m_active) begin
            if (zneg && !m1_n && !iorq_n) begin
                m_active = 0;
                push_ev(EV_ACK, stamp, nt);
                push_ev(EV_END, stamp, nt);
            end else if (!int_en) begin
                m_active = 0;
                push_ev(EV_END, stamp, nt);
            end else if (zpos) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 0;
                    push_ev(EV_END, stamp, nt);
                end
            end
        end else if (zpos && int_en && m_tcnt == int'(int_pos)) begin
            m_active = 1;
            m_rem = W;
            push_ev(EV_START, stamp, nt);
        end
        m_tcnt = nt;
    endtask

    task automatic apply_stimulus();
        @(posedge fclk);
        #1;
        if (tc_chk % 37 == 0) check_output("tcnt_track", int'(tcnt), m_tcnt);
        tc_chk++;
        m1_n = 1'b1;
        iorq_n = 1'b1;
        frame_sync = 1'b0;
        if (rnd_mode) begin
            zpos = ($urandom_range(0, 2) == 0);
            zneg = !zpos && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 39) == 0) int_en = !int_en;
            frame_sync = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) begin
                m1_n = 1'b0;
                iorq_n = 1'b0;
            end
            if ($urandom_range(0, 499) == 0) int_pos = 17'($urandom_range(0, 119));
        end else begin
            zpos = (ph == 0);
            zneg = (ph == 2);
            if (fs57_mode && m_tcnt == 57 && ph == 1) frame_sync = 1'b1;
            if (fs10_mode && zpos && m_tcnt == 10) frame_sync = 1'b1;
            ph = (ph + 1) % 4;
            if (ack_mode && m_active && m_rem == W - 1) begin
                m1_n = 1'b0;
                iorq_n = 1'b0;
            end
            if (dis_mode) int_en = !(m_active && m_rem <= W - 2);
        end
        model_step();
    endtask

    task automatic run(int n);
        repeat (n) apply_stimulus();
    endtask

    initial forever begin
        @(posedge fclk);
        edge_count++;
    end

    task automatic match_event(int kind);
        int idx;
        idx = -1;
        foreach (expq[i]) if (idx < 0 && expq[i].stamp == edge_count && expq[i].kind == kind) idx = i;
        if (idx < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_%s: DUT emitted at edge %0d, model expected none", ev_name(kind), edge_count);
        end else begin
            check_output({ev_name(kind), "_tcnt"}, int'(tcnt), expq[idx].tc);
            expq.delete(idx);
        end
    endtask

    // Monitor: drains the model's expectations as the DUT produces events.
    initial begin
        bit prev_n;
        prev_n = 1'b1;
        forever begin
            @(negedge fclk);
            if (rst || !mon_on) begin
                prev_n = int_n;
                continue;
            end
            while (expq.size() > 0 && expq[0].stamp < edge_count) begin
                checks++;
                failures++;
                $display("[TB] FAIL missing_%s: expected at edge %0d, DUT did not emit (got none, required 1)",
                         ev_name(expq[0].kind), expq[0].stamp);
                void'(expq.pop_front());
            end
            if (int_start === 1'b1) begin
                start_cnt++;
                match_event(EV_START);
                check_output("int_n_at_start", int'(int_n), 0);
            end
            if (int_ack === 1'b1) match_event(EV_ACK);
            if (!prev_n && int_n === 1'b1) match_event(EV_END);
            prev_n = int_n;
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        zpos = 0; zneg = 0; frame_sync = 0; int_en = 0; m1_n = 1; iorq_n = 1;
        int_pos = 17'd10;
        repeat (3) @(posedge fclk);
        #2;
        check_output("reset_tcnt", int'(tcnt), 0);
        check_output("reset_int_n", int'(int_n), 1);
        check_output("reset_int_start", int'(int_start), 0);
        check_output("reset_int_ack", int'(int_ack), 0);
        @(posedge fclk);
        #1;
        rst = 1'b0;
        mon_on = 1;
        int_en = 1'b1;

        run(1200);
        int_pos = 17'd99;
        run(800);
        int_pos = 17'd10;
        ack_mode = 1; run(800); ack_mode = 0;
        fs57_mode = 1; run(1000); fs57_mode = 0;
        fs10_mode = 1; run(200); fs10_mode = 0;
        dis_mode = 1; run(800); dis_mode = 0;
        int_en = 1'b1;

        int_pos = 17'd150;
        start_cnt = 0;
        run(1200);
        check_output("out_of_range_starts", start_cnt, 0);

        int_pos = 17'd10;
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (m_active && m_rem == 2) found = 1;
            else apply_stimulus();
        end
        check_output("reached_mid_int", int'(found), 1);
        @(posedge fclk);
        #1;
        check_output("int_n_before_rst", int'(int_n), 0);
        rst = 1'b1;
        zpos = 0; zneg = 0; frame_sync = 0;
        #1;
        check_output("async_rst_int_n", int'(int_n), 1);
        check_output("async_rst_tcnt", int'(tcnt), 0);
        m_active = 0;
        m_tcnt = 0;
        ph = 0;
        repeat (2) @(posedge fclk);
        #1;
        rst = 1'b0;
        run(800);

        rnd_mode = 1; run(6000); rnd_mode = 0;
        int_en = 1'b0;
        run(10);
        check_output("queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zint_gen.md
Name: zint_gen

Overview:
- Z80 maskable-interrupt timing generator.
- Counts Z80 T-states within a video frame.
- At a programmable frame position, emits a one-fclk `int_start` strobe and drives a fixed-width `int_n` pulse to the CPU.
- Sits directly upstream of the NMI generator, which consumes `int_start` to launch pending NMIs. It also feeds the CPU INT pin.

Parameters:
- FRAME_LEN, 71680, T-states per frame; frame counter wraps to 0 after FRAME_LEN-1.
- INT_WIDTH, 32, INT_N active length in T-states (zpos strobes); legal range 1..63.

Ports:
- fclk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- zpos  input  1  one-fclk strobe at each Z80 clock rising edge
- zneg  input  1  one-fclk strobe at each Z80 clock falling edge
- frame_sync  input  1  one-fclk strobe from video at frame start; resynchronises counter
- int_en  input  1  interrupt generation enable
- int_pos  input  17  T-state within frame at which INT begins
- m1_n  input  1  Z80 M1
- iorq_n  input  1  Z80 IORQ
- int_start  output  1  one-fclk strobe, INT begins (to NMI generator)
- int_n  output  1  registered INT to CPU, 0 = active
- int_ack  output  1  one-fclk strobe, CPU acknowledged INT
- tcnt  output  17  current frame T-state counter

Behaviour:
- Reset (async, rst=1) values:
  - tcnt=0, state IDLE
  - int_n=1, int_start=0, int_ack=0
  - width counter 0
  - All outputs are registered.
- Frame counter:
  - On an fclk edge with frame_sync=1, tcnt<=0. frame_sync has priority over zpos.
  - Otherwise, on zpos: tcnt<=tcnt+1, or 0 if tcnt==FRAME_LEN-1.
  - Otherwise tcnt holds.
- Match:
  - Defined as zpos && int_en && tcnt==int_pos && state==IDLE.
  - The comparison uses the tcnt register value before that edge's update.
  - If int_pos>=FRAME_LEN, a match never occurs.
  - A match is still evaluated in the same cycle as frame_sync.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on match. On that edge:
    - int_start<=1 for exactly one fclk.
    - int_n<=0.
    - width counter <= INT_WIDTH.
  - ACTIVE, on each zpos: width counter decrements. When it reaches 0 (the edge consuming the INT_WIDTH-th zpos after entry), state goes to IDLE and int_n<=1.
  - ACTIVE, INTACK: m1_n==0 && iorq_n==0 sampled on an fclk edge with zneg=1. On that edge:
    - state goes to IDLE, int_n<=1.
    - int_ack<=1 for one fclk.
    - INTACK has priority over the width decrement in the same cycle.
  - ACTIVE, int_en==0: on the next edge, state goes to IDLE and int_n<=1. No int_ack is issued.
  - A match condition while ACTIVE is impossible by definition: no second int_start, and the width is not reloaded.
- INTACK while IDLE is ignored (int_ack stays 0).
- int_start never asserts more than once per ACTIVE episode. Consecutive int_start pulses are at least INT_WIDTH zpos apart.
- Changing int_pos mid-frame takes effect at the next compare. No latching.
- Reset asserted while ACTIVE: int_n returns to 1 immediately (async). After release, the block is in IDLE with tcnt=0.
- Width counter: 6 bits. Frame counter: 17 bits, unsigned.

Test Plan:
- Basic INT (FRAME_LEN=100, INT_WIDTH=4, int_pos=10, int_en=1, zpos every 4 fclk, after reset):
  - int_start pulses once, on the edge consuming the zpos where tcnt==10.
  - int_n=0 for exactly 4 zpos periods (16 fclk), then returns to 1.
  - Repeats every 100 zpos.
- Wrap (FRAME_LEN=100, int_pos=99):
  - tcnt sequence is 98, 99, 0, 1.
  - INT starts when tcnt==99 and continues across the wrap. It ends after 4 zpos (at tcnt==3).
- Early INTACK:
  - Drive m1_n=0, iorq_n=0 with zneg during the 2nd T-state of INT.
  - int_ack pulses for 1 fclk and int_n goes to 1 on that same edge.
  - No further int_start until the next frame.
- frame_sync resync:
  - Pulse frame_sync while tcnt==57: tcnt becomes 0 on that edge.
  - The next INT occurs 10 zpos later.
  - frame_sync coincident with zpos at tcnt==10 still produces int_start, and tcnt becomes 0.
- Disable and out-of-range:
  - Drop int_en mid-INT: int_n goes to 1 next edge, int_ack=0.
  - int_pos=150 with FRAME_LEN=100: no int_start for 3 full frames.
- Async reset mid-INT:
  - Assert rst while int_n=0: int_n=1 immediately and tcnt=0.
  - After release, the first INT occurs when tcnt reaches 10.
